delay_buffer_prog: RTL and testbench

//  Complex-sample delay line with a runtime-programmable length, for SDF FFT stages and FMCW range/Doppler alignment.

---
 rtl/delay_buffer_prog.sv | 136 +++++++++++++
 tb/tb_delay_buffer_prog.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_buffer_prog.sv
// Complex-sample delay line with runtime-programmable length, counted in accepted samples.
// Storage is a circular buffer addressed by a write pointer that wraps at the programmed length.
module delay_buffer_prog #(
  parameter  int WIDTH     = 16,
  parameter  int MAX_DEPTH = 32,
  localparam int LEN_W     = $clog2(MAX_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             cfg_load,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             full,
  output logic [LEN_W-1:0] fill_cnt,
  output logic             cfg_err
);

  localparam int              PTR_W   = $clog2(MAX_DEPTH);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DEPTH);
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

  logic [2*WIDTH-1:0] mem [0:MAX_DEPTH-1];

  logic [LEN_W-1:0] len_q, len_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic             do_en_q, do_en_d;
  logic [WIDTH-1:0] do_re_q, do_re_d;
  logic [WIDTH-1:0] do_im_q, do_im_d;

  logic [2*WIDTH-1:0] rd_data_s;
  logic               wr_en_s;
  logic               ptr_last_s;

  assign rd_data_s  = mem[wr_ptr_q];
  assign wr_en_s    = di_en & ~flush & ~cfg_load;
  assign ptr_last_s = (LEN_W'(wr_ptr_q) == (len_q - ONE_LEN));

  // Next-state logic: cfg_load beats flush, flush beats an accept
  always_comb begin
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    full_d   = full_q;
    err_d    = err_q;
    do_en_d  = 1'b0;
    do_re_d  = do_re_q;
    do_im_d  = do_im_q;
    if (cfg_load) begin
      if (cfg_len == LEN_W'(0)) begin
        len_d = ONE_LEN;
        err_d = 1'b1;
      end else if (cfg_len > MAX_LEN) begin
        len_d = MAX_LEN;
        err_d = 1'b1;
      end else begin
        len_d = cfg_len;
        err_d = 1'b0;
      end
      wr_ptr_d = PTR_W'(0);
      fill_d   = LEN_W'(0);
      full_d   = 1'b0;
      do_re_d  = WIDTH'(0);
      do_im_d  = WIDTH'(0);
    end else if (flush) begin
      wr_ptr_d = PTR_W'(0);
      fill_d   = LEN_W'(0);
      full_d   = 1'b0;
      do_re_d  = WIDTH'(0);
      do_im_d  = WIDTH'(0);
    end else if (di_en) begin
      wr_ptr_d = ptr_last_s ? PTR_W'(0) : (wr_ptr_q + PTR_W'(1));
      if (fill_q == len_q) begin
        // Line already holds len_q samples: the slot being overwritten is the delayed one
        fill_d  = fill_q;
        full_d  = 1'b1;
        do_en_d = 1'b1;
        do_re_d = rd_data_s[2*WIDTH-1:WIDTH];
        do_im_d = rd_data_s[WIDTH-1:0];
      end else begin
        fill_d = fill_q + ONE_LEN;
        full_d = ((fill_q + ONE_LEN) == len_q);
      end
    end else begin
      do_en_d = 1'b0;
    end
  end

  // Control and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q    <= MAX_LEN;
      wr_ptr_q <= PTR_W'(0);
      fill_q   <= LEN_W'(0);
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      do_en_q  <= 1'b0;
      do_re_q  <= WIDTH'(0);
      do_im_q  <= WIDTH'(0);
    end else begin
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      full_q   <= full_d;
      err_q    <= err_d;
      do_en_q  <= do_en_d;
      do_re_q  <= do_re_d;
      do_im_q  <= do_im_d;
    end
  end

  // Sample storage, deliberately without reset so it maps onto RAM
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem[wr_ptr_q] <= {di_re, di_im};
    end else begin
      mem[wr_ptr_q] <= mem[wr_ptr_q];
    end
  end

  assign do_en    = do_en_q;
  assign do_re    = do_re_q;
  assign do_im    = do_im_q;
  assign full     = full_q;
  assign fill_cnt = fill_q;
  assign cfg_err  = err_q;

endmodule

// File: tb/tb_delay_buffer_prog.sv
// Table-driven bench for delay_buffer_prog: vector records carry inputs and expected outputs.
module tb_delay_buffer_prog;

  localparam int WIDTH     = 16;
  localparam int MAX_DEPTH = 32;
  localparam int LEN_W     = 6;

  logic             clock    = 1'b0;
  logic             reset    = 1'b1;
  logic             flush    = 1'b0;
  logic             cfg_load = 1'b0;
  logic [LEN_W-1:0] cfg_len  = '0;
  logic             di_en    = 1'b0;
  logic [WIDTH-1:0] di_re    = '0;
  logic [WIDTH-1:0] di_im    = '0;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic             full;
  logic [LEN_W-1:0] fill_cnt;
  logic             cfg_err;

  delay_buffer_prog #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush), .cfg_load(cfg_load), .cfg_len(cfg_len),
    .di_en(di_en), .di_re(di_re), .di_im(di_im), .do_en(do_en), .do_re(do_re),
    .do_im(do_im), .full(full), .fill_cnt(fill_cnt), .cfg_err(cfg_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             flush;
    logic             cfg_load;
    logic [LEN_W-1:0] cfg_len;
    logic             di_en;
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    logic             exp_en;
    logic [WIDTH-1:0] exp_re;
    logic [WIDTH-1:0] exp_im;
    logic             exp_full;
    logic [LEN_W-1:0] exp_fill;
    logic             exp_err;
  } vec_t;

  vec_t vq[$];
  logic [WIDTH-1:0] hist[$];
  int tests = 0;
  int fails = 0;
  int cur_len = MAX_DEPTH;
  logic cur_err = 1'b0;
  int acc = 0;
  logic [WIDTH-1:0] last_re = '0;
  logic [WIDTH-1:0] last_im = '0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic model_clear();
    acc = 0;
    hist.delete();
    last_re = '0;
    last_im = '0;
  endtask

  function automatic vec_t blank();
    vec_t v;
    v = '{flush: 1'b0, cfg_load: 1'b0, cfg_len: '0, di_en: 1'b0, re: '0, im: '0,
          exp_en: 1'b0, exp_re: '0, exp_im: '0, exp_full: 1'b0, exp_fill: '0, exp_err: 1'b0};
    return v;
  endfunction

  // cfg_load is issued together with a valid sample to show that the sample is dropped
  task automatic push_cfg(input logic [LEN_W-1:0] c, input int exp_len, input logic exp_err);
    vec_t v;
    v = blank();
    v.cfg_load = 1'b1;
    v.cfg_len  = c;
    v.di_en    = 1'b1;
    v.re       = 16'hbeef;
    v.im       = 16'h4110;
    cur_len = exp_len;
    cur_err = exp_err;
    model_clear();
    v.exp_err = exp_err;
    vq.push_back(v);
  endtask

  task automatic push_flush(input logic with_data);
    vec_t v;
    v = blank();
    v.flush   = 1'b1;
    v.di_en   = with_data;
    v.re      = 16'hdead;
    v.im      = 16'h0bad;
    model_clear();
    v.exp_err = cur_err;
    vq.push_back(v);
  endtask

  task automatic push_accept(input logic [WIDTH-1:0] val);
    vec_t v;
    v = blank();
    v.di_en = 1'b1;
    v.re    = val;
    v.im    = 16'(0) - val;
    acc++;
    hist.push_back(val);
    if (hist.size() > cur_len) begin
      last_re  = hist.pop_front();
      last_im  = 16'(0) - last_re;
      v.exp_en = 1'b1;
    end
    v.exp_re   = last_re;
    v.exp_im   = last_im;
    v.exp_full = (acc >= cur_len);
    v.exp_fill = LEN_W'((acc >= cur_len) ? cur_len : acc);
    v.exp_err  = cur_err;
    vq.push_back(v);
  endtask

  task automatic push_idle();
    vec_t v;
    v = blank();
    v.re       = 16'h5555;
    v.im       = 16'haaaa;
    v.exp_re   = last_re;
    v.exp_im   = last_im;
    v.exp_full = (acc >= cur_len);
    v.exp_fill = LEN_W'((acc >= cur_len) ? cur_len : acc);
    v.exp_err  = cur_err;
    vq.push_back(v);
  endtask

  task automatic push_stream(input int n, input int base, input int gaps);
    for (int k = 1; k <= n; k++) begin
      push_accept(16'(base + k));
      for (int g = 0; g < gaps; g++) push_idle();
    end
  endtask

  // Apply each record before a rising edge and compare 1ns after it
  task automatic run_queue(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      flush    = vq[i].flush;
      cfg_load = vq[i].cfg_load;
      cfg_len  = vq[i].cfg_len;
      di_en    = vq[i].di_en;
      di_re    = vq[i].re;
      di_im    = vq[i].im;
      @(posedge clock);
      #1;
      chk({tag, ".do_en"}, i, 32'(do_en), 32'(vq[i].exp_en));
      chk({tag, ".do_re"}, i, 32'(do_re), 32'(vq[i].exp_re));
      chk({tag, ".do_im"}, i, 32'(do_im), 32'(vq[i].exp_im));
      chk({tag, ".full"}, i, 32'(full), 32'(vq[i].exp_full));
      chk({tag, ".fill_cnt"}, i, 32'(fill_cnt), 32'(vq[i].exp_fill));
      chk({tag, ".cfg_err"}, i, 32'(cfg_err), 32'(vq[i].exp_err));
    end
    flush    = 1'b0;
    cfg_load = 1'b0;
    di_en    = 1'b0;
    vq.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".do_en"}, 0, 32'(do_en), 32'd0);
    chk({tag, ".do_re"}, 0, 32'(do_re), 32'd0);
    chk({tag, ".do_im"}, 0, 32'(do_im), 32'd0);
    chk({tag, ".full"}, 0, 32'(full), 32'd0);
    chk({tag, ".fill_cnt"}, 0, 32'(fill_cnt), 32'd0);
    chk({tag, ".cfg_err"}, 0, 32'(cfg_err), 32'd0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #12;
    chk_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    // len=4 gap-free: first output after the 5th accept equals 1, then n-4
    push_cfg(6'd4, 4, 1'b0);
    push_stream(20, 0, 0);
    run_queue("len4");

    // len=8 with two idle cycles after every accept
    push_cfg(6'd8, 8, 1'b0);
    push_stream(40, 200, 2);
    run_queue("gap8");

    // flush coinciding with a valid sample drops that sample
    push_cfg(6'd6, 6, 1'b0);
    push_stream(10, 300, 0);
    push_flush(1'b1);
    push_stream(8, 400, 0);
    run_queue("flush6");

    // out-of-range and in-range length programming
    push_cfg(6'd0, 1, 1'b1);
    push_stream(4, 500, 0);
    push_cfg(6'(MAX_DEPTH + 5), MAX_DEPTH, 1'b1);
    push_stream(MAX_DEPTH + 2, 600, 0);
    push_cfg(6'd3, 3, 1'b0);
    push_stream(6, 700, 0);
    run_queue("cfg");

    // full-depth wrap, then the single-sample degenerate case
    push_cfg(6'(MAX_DEPTH), MAX_DEPTH, 1'b0);
    push_stream(3 * MAX_DEPTH, 1000, 0);
    push_cfg(6'd1, 1, 1'b0);
    push_stream(10, 2000, 1);
    run_queue("wrap");

    // asynchronous reset between edges while the line is streaming with cfg_err set
    push_cfg(6'd0, 1, 1'b1);
    push_stream(5, 3000, 0);
    run_queue("pre_rst");
    #2 reset = 1'b0;
    di_en = 1'b0;
    #2;
    chk_zero("async_rst");
    #3 reset = 1'b1;
    cur_len = MAX_DEPTH;
    cur_err = 1'b0;
    model_clear();
    push_stream(MAX_DEPTH + 3, 4000, 0);
    run_queue("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
